// File: rtl/calc_input_conditioner.sv
// ---------------------------------------------------------------------------
// calc_input_conditioner
//
// Front end for the calculator's Enter/Clear push-buttons and switch bank.
// Every raw input is brought into the clock domain through a 2-flop
// synchronizer. Each button then passes through its own debounce FSM.
// Each accepted press produces exactly one single-cycle strobe. A snapshot
// of the synchronized switches is taken on the same edge as every Enter
// strobe, so downstream logic can sample operand/opcode without seeing
// raw toggling.
//
// Optional feature (compile-time macro HOLD_REPEAT_EN):
//   When defined, holding Enter in the accepted state generates extra
//   Enter strobes. The first comes after REPEAT_DELAY cycles and the rest
//   follow every REPEAT_PERIOD cycles. Each repeat also reloads the switch
//   snapshot. Clear never repeats.
//   When undefined, the hold counter does not exist and each press gives
//   exactly one strobe.
//
// Ports:
//   clock         in   1         system clock, rising edge
//   reset_n       in   1         asynchronous active-low reset
//   enter_btn     in   1         raw Enter button (1 = pressed), async
//   clear_btn     in   1         raw Clear button (1 = pressed), async
//   switches_in   in   SW_WIDTH  raw switch levels, async
//   enter_pulse   out  1         one-cycle strobe per accepted Enter press
//   clear_pulse   out  1         one-cycle strobe per accepted Clear press
//   switches_out  out  SW_WIDTH  switch snapshot taken at last enter_pulse
//   enter_level   out  1         debounced Enter level
// ---------------------------------------------------------------------------
module calc_input_conditioner #(
  parameter int SW_WIDTH        = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enter_btn,
  input  logic                clear_btn,
  input  logic [SW_WIDTH-1:0] switches_in,
  output logic                enter_pulse,
  output logic                clear_pulse,
  output logic [SW_WIDTH-1:0] switches_out,
  output logic                enter_level
);

  // The encoding places the debounced level in bit 1. That bit is 1 in
  // PRESSED and RELEASE_WAIT.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } btn_state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject timing parameters that would make the counters meaningless.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("calc_input_conditioner: invalid timing parameters");
  end

  // -------------------------------------------------------------------------
  // Input synchronizers. Bit 0 is Enter and bit 1 is Clear.
  // -------------------------------------------------------------------------
  logic [1:0]          btn_meta_reg;
  logic [1:0]          btn_sync_reg;
  logic [SW_WIDTH-1:0] sw_meta_reg;
  logic [SW_WIDTH-1:0] sw_sync_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
    end else begin
      btn_meta_reg <= {clear_btn, enter_btn};
      btn_sync_reg <= btn_meta_reg;
      sw_meta_reg  <= switches_in;
      sw_sync_reg  <= sw_meta_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Per-button debounce FSMs.
  // press_ev is combinational. It is high during the cycle in which the FSM
  // commits to PRESSED. The output strobe register captures it on that
  // same edge, which gives a total latency of 2 + DEBOUNCE_CYCLES + 1.
  // -------------------------------------------------------------------------
  logic [1:0] press_ev;

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             synced;
    logic             fsm_ev;

    assign synced = btn_sync_reg[gi];
    assign fsm_ev = (state_reg == ST_PRESS_WAIT) && synced && (cnt_reg == CNT_LAST);

    // The counter is cleared on every state change. It can only reach
    // CNT_LAST, so it never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_reg <= ST_RELEASED;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          ST_RELEASED: begin
            if (synced) begin
              state_reg <= ST_PRESS_WAIT;
              cnt_reg   <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!synced) begin
              state_reg <= ST_RELEASED;    // glitch dropped
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= ST_PRESSED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!synced) begin
              state_reg <= ST_RELEASE_WAIT;
              cnt_reg   <= '0;
            end
          end
          ST_RELEASE_WAIT: begin
            if (synced) begin
              state_reg <= ST_PRESSED;     // release bounce, no new press
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= ST_RELEASED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= ST_RELEASED;
            cnt_reg   <= '0;
          end
        endcase
      end
    end

    if (gi == 0) begin : g_enter
      assign enter_level = (state_reg == ST_PRESSED) || (state_reg == ST_RELEASE_WAIT);

`ifdef HOLD_REPEAT_EN
      // Hold-repeat timer. It runs only while Enter stays in PRESSED.
      // Phase 0 counts down the initial delay. Phase 1 counts repeat
      // periods. Leaving PRESSED, including the edge on which the FSM
      // leaves, clears the timer.
      localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
      localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

      logic [HOLD_W-1:0] hold_cnt_reg;
      logic              hold_phase_reg;
      logic              hold_active;
      logic              hold_last;
      logic              rep_ev;

      assign hold_active = (state_reg == ST_PRESSED) && synced;
      assign hold_last   = hold_phase_reg ? (hold_cnt_reg == PERIOD_LAST)
                                          : (hold_cnt_reg == DELAY_LAST);
      assign rep_ev      = hold_active && hold_last;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          hold_cnt_reg   <= '0;
          hold_phase_reg <= 1'b0;
        end else if (hold_active) begin
          if (hold_last) begin
            hold_cnt_reg   <= '0;
            hold_phase_reg <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end else begin
          hold_cnt_reg   <= '0;
          hold_phase_reg <= 1'b0;
        end
      end

      assign press_ev[gi] = fsm_ev | rep_ev;
`else
      assign press_ev[gi] = fsm_ev;
`endif
    end else begin : g_clear
      assign press_ev[gi] = fsm_ev;
    end
  end

  // -------------------------------------------------------------------------
  // Output strobes and switch snapshot.
  // When both buttons fire in the same cycle, Clear wins. The Enter event
  // is discarded and the snapshot is left alone.
  // -------------------------------------------------------------------------
  logic                enter_fire;
  logic                enter_pulse_reg;
  logic                clear_pulse_reg;
  logic [SW_WIDTH-1:0] switches_reg;

  assign enter_fire = press_ev[0] & ~press_ev[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enter_pulse_reg <= 1'b0;
      clear_pulse_reg <= 1'b0;
      switches_reg    <= '0;
    end else begin
      enter_pulse_reg <= enter_fire;
      clear_pulse_reg <= press_ev[1];
      if (enter_fire) begin
        switches_reg <= sw_sync_reg;
      end
    end
  end

  assign enter_pulse  = enter_pulse_reg;
  assign clear_pulse  = clear_pulse_reg;
  assign switches_out = switches_reg;

endmodule

// File: tb/tb_calc_input_conditioner.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for calc_input_conditioner.
// The stimulus process pushes the expected strobes (kind, cycle, snapshot)
// into a queue. The monitor pops an entry on every strobe the DUT presents
// and checks it. The monitor also flags strobes that were never expected
// and expected strobes that never arrived.
// ---------------------------------------------------------------------------
module tb_calc_input_conditioner;
  localparam int SW = 12;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enter_btn;
  logic          clear_btn;
  logic [SW-1:0] switches_in;
  logic          enter_pulse;
  logic          clear_pulse;
  logic [SW-1:0] switches_out;
  logic          enter_level;

  calc_input_conditioner #(
    .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enter_btn(enter_btn), .clear_btn(clear_btn),
    .switches_in(switches_in), .enter_pulse(enter_pulse), .clear_pulse(clear_pulse),
    .switches_out(switches_out), .enter_level(enter_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_clear;
    int            cyc;
    logic [SW-1:0] sw;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_clear, input int at, input logic [SW-1:0] sw);
    exp_t e;
    e.is_clear = is_clear;
    e.cyc      = at;
    e.sw       = sw;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse: got none expected %s pulse at cycle %0d",
               e.is_clear ? "clear" : "enter", e.cyc);
    end
    if (enter_pulse || clear_pulse) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got enter=%0b clear=%0b at cycle %0d expected no pulse",
                 enter_pulse, clear_pulse, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("pulse: enter=%0b clear=%0b cycle=%0d sw=%03h", enter_pulse, clear_pulse, cyc, switches_out);
        chk("pulse_clear", 32'(clear_pulse), 32'(e.is_clear));
        chk("pulse_enter", 32'(enter_pulse), 32'(!e.is_clear));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("snapshot", 32'(switches_out), 32'(e.sw));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] exp_sw;
    bit            pat [5];
    int            t;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // 1: reset with Enter held, then release reset.
    reset_n = 1'b0; enter_btn = 1'b1; clear_btn = 1'b0; switches_in = '0;
    exp_sw = '0;
    step(3);
    chk("rst_enter_pulse", 32'(enter_pulse), 32'd0);
    chk("rst_clear_pulse", 32'(clear_pulse), 32'd0);
    chk("rst_switches", 32'(switches_out), 32'd0);
    chk("rst_level", 32'(enter_level), 32'd0);
    reset_n = 1'b1;
    push(1'b0, cyc + 7, 12'h000);
    step(7);
    chk("t1_level_high", 32'(enter_level), 32'd1);
    step(5);
    enter_btn = 1'b0;
    step(12);
    chk("t1_level_low", 32'(enter_level), 32'd0);

    // 2: snapshot on press, held afterwards.
    switches_in = 12'h3A5; enter_btn = 1'b1;
    push(1'b0, cyc + 7, 12'h3A5);
    exp_sw = 12'h3A5;
    step(10);
    switches_in = 12'h0FF;
    step(4);
    chk("t2_snapshot_hold", 32'(switches_out), 32'(exp_sw));
    enter_btn = 1'b0;
    step(12);

    // 3: short bounces are ignored.
    for (int i = 0; i < 5; i++) begin
      enter_btn = pat[i];
      step(1);
      chk("t3_bounce_level", 32'(enter_level), 32'd0);
    end
    enter_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t3_settle_level", 32'(enter_level), 32'd0);
    end

    // 4: simultaneous press, Clear wins.
    enter_btn = 1'b1; clear_btn = 1'b1;
    push(1'b1, cyc + 7, exp_sw);
    step(12);
    chk("t4_snapshot_kept", 32'(switches_out), 32'(exp_sw));
    chk("t4_enter_level", 32'(enter_level), 32'd1);
    enter_btn = 1'b0; clear_btn = 1'b0;
    step(12);

    // 5: a short release gives no second pulse. A full release does.
    enter_btn = 1'b1;
    push(1'b0, cyc + 7, 12'h0FF);
    exp_sw = 12'h0FF;
    step(10);
    enter_btn = 1'b0;
    step(2);
    enter_btn = 1'b1;
    step(10);
    chk("t5_level_kept", 32'(enter_level), 32'd1);
    enter_btn = 1'b0;
    step(10);
    chk("t5_level_released", 32'(enter_level), 32'd0);
    enter_btn = 1'b1;
    push(1'b0, cyc + 7, 12'h0FF);
    step(10);
    enter_btn = 1'b0;
    step(12);

    // 6: long hold (auto-repeat only when the feature is compiled in).
    enter_btn = 1'b1;
    t = cyc;
    push(1'b0, t + 7, 12'h0FF);
`ifdef HOLD_REPEAT_EN
    push(1'b0, t + 27, 12'h0FF);
    push(1'b0, t + 35, 12'h5C3);
    push(1'b0, t + 43, 12'h5C3);
    push(1'b0, t + 51, 12'h5C3);
    push(1'b0, t + 59, 12'h5C3);
    exp_sw = 12'h5C3;
`endif
    step(30);
    switches_in = 12'h5C3;
    step(30);
    enter_btn = 1'b0;
    step(12);
    chk("t6_snapshot", 32'(switches_out), 32'(exp_sw));

    // 7: reset mid-debounce with Enter held. A full debounce is needed afterwards.
    enter_btn = 1'b1;
    step(4);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_pulse", 32'(enter_pulse), 32'd0);
    chk("t7_rst_switches", 32'(switches_out), 32'd0);
    chk("t7_rst_level", 32'(enter_level), 32'd0);
    step(3);
    reset_n = 1'b1;
    push(1'b0, cyc + 7, 12'h5C3);
    step(6);
    chk("t7_level_before", 32'(enter_level), 32'd0);
    step(1);
    chk("t7_level_after", 32'(enter_level), 32'd1);
    step(3);
    enter_btn = 1'b0;
    step(12);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
